// File: rtl/line_rotate_ctrl_pkg.sv
// Shared types and constants for the rotating line-buffer sequencer.
package line_rotate_ctrl_pkg;
  localparam int LINE_BUFS = 4;
  localparam logic [LINE_BUFS-1:0] WR_LINE_RST = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic logic [LINE_BUFS-1:0] rotl(input logic [LINE_BUFS-1:0] v);
    return {v[LINE_BUFS-2:0], v[LINE_BUFS-1]};
  endfunction
endpackage

// File: rtl/line_rotate_ctrl_if.sv
// Pixel-stream qualifiers in, line-buffer control out. o_sof_err exists only with LRC_RESYNC_EN.
interface line_rotate_ctrl_if import line_rotate_ctrl_pkg::*; #(
  parameter int COL_W = 9,
  parameter int ROW_W = 9
);
  logic                 i_sof;
  logic                 i_pix_valid;
  logic [LINE_BUFS-1:0] o_wr_line;
  logic [1:0]           o_sel;
  logic [COL_W-1:0]     o_col;
  logic [ROW_W-1:0]     o_row;
  logic                 o_win_valid;
  logic                 o_eol;
  logic                 o_eof;
  logic                 o_busy;
`ifdef LRC_RESYNC_EN
  logic                 o_sof_err;
`endif

  modport master (
    output i_sof, i_pix_valid,
    input  o_wr_line, o_sel, o_col, o_row, o_win_valid, o_eol, o_eof, o_busy
`ifdef LRC_RESYNC_EN
    , input o_sof_err
`endif
  );

  modport slave (
    input  i_sof, i_pix_valid,
    output o_wr_line, o_sel, o_col, o_row, o_win_valid, o_eol, o_eof, o_busy
`ifdef LRC_RESYNC_EN
    , output o_sof_err
`endif
  );
endinterface

// File: rtl/line_rotate_ctrl_pix_counter.sv
// Modulo-MAX counter with enable, sync clear (priority) and terminal-count flag.
module pix_counter #(
  parameter int CNT_W = 9,
  parameter int MAX   = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  assign tc = (cnt == CNT_W'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tc ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/line_rotate_ctrl.sv
// Column/row sequencer and line-buffer rotation for the 3x3 window stage.
// Optional LRC_RESYNC_EN: mid-frame i_sof restarts the frame and pulses o_sof_err.
module line_rotate_ctrl import line_rotate_ctrl_pkg::*; #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int COL_W      = 9,
  parameter int ROW_W      = 9
) (
  input logic               clk,
  input logic               rst_n,
  line_rotate_ctrl_if.slave bus
);
  state_t               state;
  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;
  logic                 col_tc, row_tc;
  logic                 start, adv, line_last, frame_last;
  logic [LINE_BUFS-1:0] wr_line;
  logic [1:0]           sel;
  logic                 win, eol, eof, busy;

`ifdef LRC_RESYNC_EN
  logic sof_err;
  assign start = bus.i_pix_valid && bus.i_sof;
  assign bus.o_sof_err = sof_err;
`else
  assign start = bus.i_pix_valid && bus.i_sof && (state == ST_IDLE);
`endif
  assign adv = bus.i_pix_valid && !start && (state != ST_IDLE);

  // col_q/row_q hold the previous pixel; this pixel ends its line when col_q is IMG_WIDTH-2
  assign line_last  = adv && (col_q == COL_W'(IMG_WIDTH - 2));
  assign frame_last = line_last && row_tc;

  pix_counter #(.CNT_W(COL_W), .MAX(IMG_WIDTH)) u_col (
    .clk(clk), .rst_n(rst_n), .en(adv), .clr(start), .cnt(col_q), .tc(col_tc)
  );

  pix_counter #(.CNT_W(ROW_W), .MAX(IMG_HEIGHT)) u_row (
    .clk(clk), .rst_n(rst_n), .en(adv && col_tc), .clr(start), .cnt(row_q), .tc(row_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wr_line <= WR_LINE_RST;
      sel     <= 2'd0;
      win     <= 1'b0;
      eol     <= 1'b0;
      eof     <= 1'b0;
      busy    <= 1'b0;
`ifdef LRC_RESYNC_EN
      sof_err <= 1'b0;
`endif
    end else begin
      win <= 1'b0;
      eol <= 1'b0;
      eof <= 1'b0;
`ifdef LRC_RESYNC_EN
      sof_err <= 1'b0;
`endif
      if (start) begin
        state   <= ST_FILL;
        wr_line <= WR_LINE_RST;
        sel     <= 2'd0;
        busy    <= 1'b1;
`ifdef LRC_RESYNC_EN
        sof_err <= (state != ST_IDLE);
`endif
      end else begin
        // busy stays up through the o_eof cycle and drops one cycle later
        if (state == ST_IDLE) busy <= 1'b0;
        if (adv) begin
          eol <= line_last;
          eof <= frame_last;
          win <= (state == ST_RUN);
          if (col_tc) begin
            wr_line <= rotl(wr_line);
            sel     <= sel + 2'd1;
          end
          if (state == ST_FILL && line_last && row_q == ROW_W'(1)) state <= ST_RUN;
          else if (state == ST_RUN && frame_last)                  state <= ST_IDLE;
        end
      end
    end
  end

  assign bus.o_wr_line   = wr_line;
  assign bus.o_sel       = sel;
  assign bus.o_col       = col_q;
  assign bus.o_row       = row_q;
  assign bus.o_win_valid = win;
  assign bus.o_eol       = eol;
  assign bus.o_eof       = eof;
  assign bus.o_busy      = busy;
endmodule

// File: tb/tb_line_rotate_ctrl.sv
// Directed bench: 4x4 frame on dut_a, 4x6 frame on dut_b for the rotation wrap-around.
module tb_line_rotate_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sof = 1'b0;
  logic valid = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  line_rotate_ctrl_if #(.COL_W(9), .ROW_W(9)) bus_a ();
  line_rotate_ctrl_if #(.COL_W(9), .ROW_W(9)) bus_b ();
  assign bus_a.i_sof = sof;
  assign bus_a.i_pix_valid = valid;
  assign bus_b.i_sof = sof;
  assign bus_b.i_pix_valid = valid;

  line_rotate_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .COL_W(9), .ROW_W(9)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  line_rotate_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(6), .COL_W(9), .ROW_W(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  // {wr_line, sel, col, row, win_valid, eol, eof, busy}
  logic [27:0] got_a, got_b;
  assign got_a = {bus_a.o_wr_line, bus_a.o_sel, bus_a.o_col, bus_a.o_row,
                  bus_a.o_win_valid, bus_a.o_eol, bus_a.o_eof, bus_a.o_busy};
  assign got_b = {bus_b.o_wr_line, bus_b.o_sel, bus_b.o_col, bus_b.o_row,
                  bus_b.o_win_valid, bus_b.o_eol, bus_b.o_eof, bus_b.o_busy};
  localparam logic [27:0] RST = {4'b0001, 2'b00, 9'd0, 9'd0, 4'b0000};

  task automatic pix(input logic v, input logic s);
    valid = v;
    sof   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sof   = 1'b0;
    valid = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) begin
      sof   = 1'($urandom_range(1, 0));
      valid = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
    end
    total++;
    if (got_a !== RST) begin bad++; $display("FAIL reset_a got=%h exp=%h", got_a, RST); end
    total++;
    if (got_b !== RST) begin bad++; $display("FAIL reset_b got=%h exp=%h", got_b, RST); end
`ifdef LRC_RESYNC_EN
    total++;
    if (bus_a.o_sof_err !== 1'b0) begin bad++; $display("FAIL reset_sof_err got=%b exp=0", bus_a.o_sof_err); end
`endif
    sof = 1'b0;
    valid = 1'b0;
    rst_n = 1'b1;
    pix(1'b1, 1'b0);
    pix(1'b1, 1'b0);
    total++;
    if (got_a !== RST) begin bad++; $display("FAIL idle_no_sof got=%h exp=%h", got_a, RST); end
  endtask

  task automatic test_full_frame();
    logic [27:0] exp;
    int r, c;
    do_reset();
    for (int p = 0; p < 16; p++) begin
      pix(1'b1, 1'(p == 0));
      r = p / 4;
      c = p % 4;
      exp = {4'(1 << r), 2'(r), 9'(c), 9'(r), 1'(p >= 8), 1'(c == 3), 1'(p == 15), 1'b1};
      total++;
      if (got_a !== exp) begin bad++; $display("FAIL full_frame p=%0d got=%h exp=%h", p, got_a, exp); end
    end
    pix(1'b0, 1'b0);
    exp = {4'b1000, 2'b11, 9'd3, 9'd3, 4'b0000};
    total++;
    if (got_a !== exp) begin bad++; $display("FAIL busy_drop got=%h exp=%h", got_a, exp); end
    pix(1'b1, 1'b0);
    total++;
    if (got_a !== exp) begin bad++; $display("FAIL idle_hold got=%h exp=%h", got_a, exp); end
    pix(1'b1, 1'b1);
    exp = {4'b0001, 2'b00, 9'd0, 9'd0, 4'b0001};
    total++;
    if (got_a !== exp) begin bad++; $display("FAIL next_frame got=%h exp=%h", got_a, exp); end
  endtask

  task automatic test_stall();
    logic v_tab [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   col_tab [7] = '{0, 1, 1, 2, 2, 3, 3};
    logic eol_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [27:0] exp;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      pix(v_tab[i], 1'(i == 0));
      exp = {4'b0001, 2'b00, 9'(col_tab[i]), 9'd0, 1'b0, eol_tab[i], 1'b0, 1'b1};
      total++;
      if (got_a !== exp) begin bad++; $display("FAIL stall i=%0d got=%h exp=%h", i, got_a, exp); end
    end
  endtask

  task automatic test_wrap();
    logic [27:0] exp;
    int r, c;
    do_reset();
    for (int p = 0; p < 20; p++) begin
      pix(1'b1, 1'(p == 0));
      r = p / 4;
      c = p % 4;
      exp = {4'(1 << (r % 4)), 2'(r % 4), 9'(c), 9'(r), 1'(r >= 2), 1'(c == 3), 1'b0, 1'b1};
      total++;
      if (got_b !== exp) begin bad++; $display("FAIL wrap p=%0d got=%h exp=%h", p, got_b, exp); end
    end
  endtask

  task automatic test_mid_sof();
    logic [27:0] exp;
    do_reset();
    for (int p = 0; p < 9; p++) pix(1'b1, 1'(p == 0));
    pix(1'b1, 1'b1);
`ifdef LRC_RESYNC_EN
    exp = {4'b0001, 2'b00, 9'd0, 9'd0, 4'b0001};
    total++;
    if (got_a !== exp) begin bad++; $display("FAIL resync got=%h exp=%h", got_a, exp); end
    total++;
    if (bus_a.o_sof_err !== 1'b1) begin bad++; $display("FAIL sof_err_pulse got=%b exp=1", bus_a.o_sof_err); end
    pix(1'b1, 1'b0);
    exp = {4'b0001, 2'b00, 9'd1, 9'd0, 4'b0001};
    total++;
    if (got_a !== exp) begin bad++; $display("FAIL resync_next got=%h exp=%h", got_a, exp); end
    total++;
    if (bus_a.o_sof_err !== 1'b0) begin bad++; $display("FAIL sof_err_clear got=%b exp=0", bus_a.o_sof_err); end
`else
    exp = {4'b0100, 2'b10, 9'd1, 9'd2, 4'b1001};
    total++;
    if (got_a !== exp) begin bad++; $display("FAIL mid_sof got=%h exp=%h", got_a, exp); end
    pix(1'b1, 1'b0);
    exp = {4'b0100, 2'b10, 9'd2, 9'd2, 4'b1001};
    total++;
    if (got_a !== exp) begin bad++; $display("FAIL mid_sof_next got=%h exp=%h", got_a, exp); end
`endif
  endtask

  task automatic test_async_reset();
    logic [27:0] exp;
    int r, c;
    do_reset();
    for (int p = 0; p < 10; p++) pix(1'b1, 1'(p == 0));
    exp = {4'b0100, 2'b10, 9'd1, 9'd2, 4'b1001};
    total++;
    if (got_a !== exp) begin bad++; $display("FAIL pre_async got=%h exp=%h", got_a, exp); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (got_a !== RST) begin bad++; $display("FAIL async_reset got=%h exp=%h", got_a, RST); end
    #1 rst_n = 1'b1;
    for (int p = 0; p < 16; p++) begin
      pix(1'b1, 1'(p == 0));
      r = p / 4;
      c = p % 4;
      exp = {4'(1 << r), 2'(r), 9'(c), 9'(r), 1'(p >= 8), 1'(c == 3), 1'(p == 15), 1'b1};
      total++;
      if (got_a !== exp) begin bad++; $display("FAIL clean_frame p=%0d got=%h exp=%h", p, got_a, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_wrap();
    test_mid_sof();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_rotate_ctrl.md
Name: line_rotate_ctrl

Overview:
- Sequencer for the 4-line rotating line-buffer stage that feeds the 3x3 window filters.
- Counts the columns and rows of each incoming pixel, picks the line buffer written by each pixel, and drives the 2-bit rotation select to the 4:1 8-bit line-select muxes.
- Flags when a full 3-line window is valid, and marks end-of-line and end-of-frame.

Parameters:
- IMG_WIDTH, 256, pixels per line (>=4)
- IMG_HEIGHT, 256, lines per frame (>=3)
- COL_W, 9, column counter width; must hold IMG_WIDTH-1
- ROW_W, 9, row counter width; must hold IMG_HEIGHT-1

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_sof  input  1  start-of-frame pulse, qualified by i_pix_valid
- i_pix_valid  input  1  one pixel accepted this cycle
- o_wr_line  output  4  one-hot write enable, one bit per line buffer
- o_sel  output  2  rotation select to the line-select muxes
- o_col  output  COL_W  column of the accepted pixel
- o_row  output  ROW_W  row of the accepted pixel
- o_win_valid  output  1  3x3 window around (o_row-1, o_col) is valid
- o_eol  output  1  last pixel of a line
- o_eof  output  1  last pixel of a frame
- o_busy  output  1  frame in progress

Behaviour:
- Interface fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- All outputs are registered and appear 1 cycle after the accepting i_pix_valid edge.
- Reset values:
  - state=IDLE, o_wr_line=4'b0001, o_sel=2'b00
  - o_col=0, o_row=0
  - o_win_valid=0, o_eol=0, o_eof=0, o_busy=0
- FSM states: IDLE, FILL, RUN.
  - IDLE: i_pix_valid with i_sof -> FILL. This pixel is col 0, row 0. Rotation restarts: o_wr_line=0001, o_sel=00. o_busy=1.
  - IDLE: i_pix_valid without i_sof -> pixel ignored, all outputs hold.
  - FILL: rows 0 and 1 are being written. The transition that completes row 1 -> RUN.
  - RUN: rows 2..IMG_HEIGHT-1. The transition on the last pixel of the frame -> IDLE.
- Column counter:
  - Increments on each accepted pixel.
  - At IMG_WIDTH-1 it wraps to 0 and asserts o_eol for that pixel.
  - Rows increment on each wrap.
- Line rotation on each line wrap:
  - o_wr_line rotates left: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - o_sel increments mod 4.
  - o_sel is the index of the oldest stored line, so the mux output order is oldest -> newest.
- o_win_valid = 1 only for pixels accepted in RUN.
- o_eof = 1 on the pixel where col=IMG_WIDTH-1 and row=IMG_HEIGHT-1. It coincides with o_eol. o_busy drops the following cycle.
- i_pix_valid=0 stalls every counter. The pulse outputs (o_win_valid, o_eol, o_eof) are 0 in stall cycles. o_col, o_row, o_sel and o_wr_line hold.
- i_sof mid-frame (FILL or RUN) is ignored unless LRC_RESYNC_EN is defined.
- Asynchronous reset mid-frame returns to the reset values immediately; the partial frame is discarded.

Optional Feature:
- Macro: LRC_RESYNC_EN.
- Defined:
  - Adds output o_sof_err (1-bit, reset 0).
  - i_sof with i_pix_valid in FILL or RUN pulses o_sof_err for one cycle.
  - The counters and rotation restart exactly as from IDLE; that pixel becomes col 0, row 0, state FILL.
- Undefined:
  - o_sof_err does not exist.
  - A mid-frame i_sof is treated as an ordinary pixel.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_FILL=2'd1, ST_RUN=2'd2
  - LINE_BUFS=4
  - the one-hot reset constant 4'b0001
- One sub-module is natural: pix_counter, a parameterised wrap counter with enable, terminal-count flag and sync clear. It is used twice (column and row).

Test Plan:
- Reset: rst_n low with random inputs -> o_wr_line=0001, o_sel=00, o_busy=0, all pulse outputs 0. Release, then i_pix_valid without i_sof -> no output change.
- Full frame, IMG_WIDTH=4, IMG_HEIGHT=4, continuous valid from i_sof:
  - o_eol on pixels 3, 7, 11, 15.
  - o_win_valid on pixels 8..15 only.
  - o_eof on pixel 15; o_busy=0 one cycle later.
  - o_sel sequence 00, 01, 10, 11.
- Stall: valid toggled 1010 mid-line -> o_col advances only on valid cycles; o_win_valid/o_eol are 0 in stall cycles.
- Wrap-around: 5 lines with IMG_HEIGHT=6 -> o_wr_line goes 0001, 0010, 0100, 1000, 0001; o_sel=00 on line 4.
- Mid-frame i_sof at row 2, col 1:
  - Without LRC_RESYNC_EN: treated as a normal pixel, o_col=1.
  - With LRC_RESYNC_EN: o_sof_err pulses once; o_col=0, o_row=0, o_wr_line=0001.
- Asynchronous reset asserted mid-RUN between clock edges -> outputs go to reset values before the next edge. The next i_sof starts a clean frame.
